multicycle_controller: RTL and testbench

- Main control FSM for the multicycle RV32I-subset core.
- Sequences the single shared ALU across fetch, address, execute and branch phases.
- Drives the datapath mux selects and write enables. Instantiates alu_decoder to produce alu_control.
- Sits between the instruction register (op/funct fields), the ALU zero flag and the unified instruction/data memory, whose completion is signalled by mem_ready.

---
 rtl/cpu_pkg.sv | 62 ++++++
 rtl/alu_decoder.sv | 37 +++
 rtl/multicycle_controller.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the multicycle RV32I-subset core.
// Holds the controller state encoding, opcode constants, ALU operation
// classes, ALU control codes and the datapath mux-select encodings.
package cpu_pkg;

  // Controller states; encodings 12-15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  // Opcodes
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALU operation class handed to alu_decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU control codes produced by alu_decoder
  localparam logic [3:0] ALUC_AND  = 4'b0000;
  localparam logic [3:0] ALUC_OR   = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SLL  = 4'b0011;
  localparam logic [3:0] ALUC_XOR  = 4'b0100;
  localparam logic [3:0] ALUC_SRL  = 4'b0101;
  localparam logic [3:0] ALUC_SUB  = 4'b0110;
  localparam logic [3:0] ALUC_SLT  = 4'b0111;
  localparam logic [3:0] ALUC_SLTU = 4'b1000;
  localparam logic [3:0] ALUC_SRA  = 4'b1001;

  // Result mux
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A mux
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B mux
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps the controller's ALU operation class plus funct fields
// to a 4-bit ALU control code. Purely combinational.
// Ports: alu_op (class), funct3, funct7_b5 (already qualified by op[5]),
//        alu_control (operation to the ALU).
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALUC_ADD;
    case (alu_op)
      ALU_OP_ADD: alu_control = ALUC_ADD;
      ALU_OP_SUB: alu_control = ALUC_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = funct7_b5 ? ALUC_SUB : ALUC_ADD;
          3'b001:  alu_control = ALUC_SLL;
          3'b010:  alu_control = ALUC_SLT;
          3'b011:  alu_control = ALUC_SLTU;
          3'b100:  alu_control = ALUC_XOR;
          // funct7_b5 arrives masked by op[5], so only register-form
          // shifts can select the arithmetic variant.
          3'b101:  alu_control = funct7_b5 ? ALUC_SRA : ALUC_SRL;
          3'b110:  alu_control = ALUC_OR;
          default: alu_control = ALUC_AND;
        endcase
      end
      default: alu_control = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multicycle RV32I-subset core.
// Sequences the shared ALU through fetch/decode/address/execute/branch phases
// and drives the datapath mux selects and write enables (Moore decode plus
// mem_ready/zero gating). MEM_WAIT_EN=0 treats memory as always ready.
// Ports: clk, reset (sync, active-high); op/funct3/funct7_b5 from the IR;
//        zero from the ALU; mem_ready from memory; pc_write, adr_src,
//        mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b,
//        alu_control to the datapath; retire, illegal, state_o for status.
module multicycle_controller
  import cpu_pkg::*;
#(
  parameter logic MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic       retire,
  output logic       illegal,
  output logic [3:0] state_o
);

  state_t     state_q, state_d;
  logic       illegal_q;
  logic       mem_rdy;
  logic [1:0] alu_op;
  logic       funct7_eff;

  assign mem_rdy = MEM_WAIT_EN ? mem_ready : 1'b1;

  // Only R-type (op[5]=1) may request SUB via bit 30; for I-type that bit
  // is immediate data.
  assign funct7_eff = funct7_b5 & op[5];

  // State and sticky illegal flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_q | (state_d == S_ILLEGAL);
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    retire     = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALU_OP_ADD;

    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = mem_rdy;
        pc_write   = mem_rdy;
      end
      S_DECODE: begin
        // Branch/jump target computed early into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        retire    = mem_rdy;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_FUNCT;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_OP_FUNCT;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JAL: begin
        // oldPC+4 goes to ALUOut for the link write; PC takes the
        // target already sitting in ALUOut.
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALU_OP_SUB;
        pc_write  = zero;
        retire    = 1'b1;
      end
      default: ;
    endcase

    // Reset wins over everything: no writes, FETCH selects.
    if (reset) begin
      pc_write   = 1'b0;
      adr_src    = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      retire     = 1'b0;
      result_src = RES_ALURESULT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_FOUR;
      alu_op     = ALU_OP_ADD;
    end
  end

  assign illegal = illegal_q | (state_q >= S_ILLEGAL);
  assign state_o = state_q;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7_b5   (funct7_eff),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: the driver pushes a
// hand-written expected output vector per cycle; the monitor pops and
// compares it on the falling edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] st;
    logic [4:0] en;   // {pc_write, ir_write, reg_write, mem_write, retire}
    logic       adr;
    logic [1:0] res;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] aluc;
    logic       ill;
  } exp_t;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [3:0] alu_control;
  logic       retire, illegal;
  logic [3:0] state_o;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   vec_no = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_WAIT_EN(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7_b5   (funct7_b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .retire      (retire),
    .illegal     (illegal),
    .state_o     (state_o)
  );

  task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    op = o;
    funct3 = f3;
    funct7_b5 = f7;
  endtask

  // Drive one cycle of inputs, queue its expected outputs, advance a clock.
  task automatic cyc(input logic rst, input logic rdy, input logic z,
                     input logic [3:0] st, input logic [4:0] en, input logic adr,
                     input logic [1:0] res, input logic [1:0] a, input logic [1:0] b,
                     input logic [3:0] aluc, input logic ill);
    exp_t e;
    reset = rst;
    mem_ready = rdy;
    zero = z;
    e = '{st: st, en: en, adr: adr, res: res, a: a, b: b, aluc: aluc, ill: ill};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        g = '{st: state_o, en: {pc_write, ir_write, reg_write, mem_write, retire},
              adr: adr_src, res: result_src, a: alu_src_a, b: alu_src_b,
              aluc: alu_control, ill: illegal};
        checks++;
        if (g === e) passes++;
        else
          $display("FAIL vec%0d: got st=%0d en=%b adr=%b res=%b a=%b b=%b aluc=%b ill=%b, exp st=%0d en=%b adr=%b res=%b a=%b b=%b aluc=%b ill=%b",
                   vec_no, g.st, g.en, g.adr, g.res, g.a, g.b, g.aluc, g.ill,
                   e.st, e.en, e.adr, e.res, e.a, e.b, e.aluc, e.ill);
        vec_no++;
      end
    end
  end

  initial begin
    int wait_cnt;
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b0;
    instr(7'b0110011, 3'b000, 1'b1);
    @(posedge clk); #1;
    // Second reset cycle: state already FETCH, no enables
    cyc(1,1,0, 4'd0,  5'b00000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);

    // R-type sub: 0,1,6,8
    cyc(0,1,0, 4'd0,  5'b11000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd1,  5'b00000, 0, 2'b00, 2'b01, 2'b01, ADD, 0);
    cyc(0,1,0, 4'd6,  5'b00000, 0, 2'b00, 2'b10, 2'b00, SUB, 0);
    cyc(0,1,0, 4'd8,  5'b00101, 0, 2'b00, 2'b00, 2'b00, ADD, 0);

    // addi with imm bit5=1 must stay ADD
    instr(7'b0010011, 3'b000, 1'b1);
    cyc(0,1,0, 4'd0,  5'b11000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd1,  5'b00000, 0, 2'b00, 2'b01, 2'b01, ADD, 0);
    cyc(0,1,0, 4'd7,  5'b00000, 0, 2'b00, 2'b10, 2'b01, ADD, 0);
    cyc(0,1,0, 4'd8,  5'b00101, 0, 2'b00, 2'b00, 2'b00, ADD, 0);

    // lw: 3 FETCH waits, 2 MEMREAD waits -> 10 cycles
    instr(7'b0000011, 3'b010, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc(0,0,0, 4'd0, 5'b00000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd0,  5'b11000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd1,  5'b00000, 0, 2'b00, 2'b01, 2'b01, ADD, 0);
    cyc(0,1,0, 4'd2,  5'b00000, 0, 2'b00, 2'b10, 2'b01, ADD, 0);
    for (int i = 0; i < 2; i++)
      cyc(0,0,0, 4'd3, 5'b00000, 1, 2'b00, 2'b00, 2'b00, ADD, 0);
    cyc(0,1,0, 4'd3,  5'b00000, 1, 2'b00, 2'b00, 2'b00, ADD, 0);
    cyc(0,1,0, 4'd4,  5'b00101, 0, 2'b01, 2'b00, 2'b00, ADD, 0);

    // beq taken then not taken
    instr(7'b1100011, 3'b000, 1'b0);
    cyc(0,1,0, 4'd0,  5'b11000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd1,  5'b00000, 0, 2'b00, 2'b01, 2'b01, ADD, 0);
    cyc(0,1,1, 4'd10, 5'b10001, 0, 2'b00, 2'b10, 2'b00, SUB, 0);
    cyc(0,1,0, 4'd0,  5'b11000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd1,  5'b00000, 0, 2'b00, 2'b01, 2'b01, ADD, 0);
    cyc(0,1,0, 4'd10, 5'b00001, 0, 2'b00, 2'b10, 2'b00, SUB, 0);

    // sw with 2 MEMWRITE waits
    instr(7'b0100011, 3'b010, 1'b0);
    cyc(0,1,0, 4'd0,  5'b11000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd1,  5'b00000, 0, 2'b00, 2'b01, 2'b01, ADD, 0);
    cyc(0,1,0, 4'd2,  5'b00000, 0, 2'b00, 2'b10, 2'b01, ADD, 0);
    for (int i = 0; i < 2; i++)
      cyc(0,0,0, 4'd5, 5'b00010, 1, 2'b00, 2'b00, 2'b00, ADD, 0);
    cyc(0,1,0, 4'd5,  5'b00011, 1, 2'b00, 2'b00, 2'b00, ADD, 0);

    // jal: 0,1,9,8
    instr(7'b1101111, 3'b000, 1'b0);
    cyc(0,1,0, 4'd0,  5'b11000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd1,  5'b00000, 0, 2'b00, 2'b01, 2'b01, ADD, 0);
    cyc(0,1,0, 4'd9,  5'b10000, 0, 2'b00, 2'b01, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd8,  5'b00101, 0, 2'b00, 2'b00, 2'b00, ADD, 0);

    // Unsupported opcode: ILLEGAL held, sticky flag, no enables
    instr(7'b1110011, 3'b000, 1'b0);
    cyc(0,1,0, 4'd0,  5'b11000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd1,  5'b00000, 0, 2'b00, 2'b01, 2'b01, ADD, 0);
    for (int i = 0; i < 5; i++)
      cyc(0,1,1, 4'd11, 5'b00000, 0, 2'b00, 2'b00, 2'b00, ADD, 1);
    // Reset out of ILLEGAL: flag clears on the edge
    cyc(1,1,0, 4'd11, 5'b00000, 0, 2'b10, 2'b00, 2'b10, ADD, 1);

    // lw interrupted by reset in MEMREAD while mem_ready=1
    instr(7'b0000011, 3'b010, 1'b0);
    cyc(0,1,0, 4'd0,  5'b11000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd1,  5'b00000, 0, 2'b00, 2'b01, 2'b01, ADD, 0);
    cyc(0,1,0, 4'd2,  5'b00000, 0, 2'b00, 2'b10, 2'b01, ADD, 0);
    cyc(1,1,0, 4'd3,  5'b00000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd0,  5'b11000, 0, 2'b10, 2'b00, 2'b10, ADD, 0);
    cyc(0,1,0, 4'd1,  5'b00000, 0, 2'b00, 2'b01, 2'b01, ADD, 0);

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (sb.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected vectors left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
